// File: rtl/cv32e40x_alu_b_count_unit.sv
// Pipelined CPOP/CLZ/CTZ count unit: conditions the operand into a mask whose
// population count is the result, then popcounts it behind valid/ready handshakes.
module cv32e40x_alu_b_count_unit #(
    parameter int unsigned PREP_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kill_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  operator_i,
    input  logic [31:0] operand_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;

    logic [DATA_W-1:0] rev_c;
    logic [DATA_W-1:0] mask_c;
    logic [DATA_W-1:0] cnt_src;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              s2_valid_d;
    logic              s2_valid_q;
    logic              s2_can_load;
    logic              s2_load;
    logic              in_fire;

    // CLZ reuses the trailing-zero mask on the bit-reversed operand
    always_comb begin
        rev_c = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            rev_c[i] = operand_i[DATA_W-1-i];
        end
        mask_c = operand_i;
        case (operator_i)
            2'b01:   mask_c = ~rev_c & (rev_c - DATA_W'(1));
            2'b10:   mask_c = ~operand_i & (operand_i - DATA_W'(1));
            default: mask_c = operand_i;
        endcase
    end

    assign s2_can_load = !s2_valid_q || out_ready_i;
    assign in_fire     = in_valid_i && in_ready_o;

    generate
        if (PREP_REG != 0) begin : g_prep
            logic              s1_valid_q;
            logic              s1_valid_d;
            logic              s1_adv;
            logic [DATA_W-1:0] mask_q;

            assign s1_adv     = s1_valid_q && s2_can_load;
            assign in_ready_o = !rst && !kill_i && (!s1_valid_q || s1_adv);
            assign s2_load    = s1_adv && !kill_i;
            assign cnt_src    = mask_q;

            always_comb begin
                s1_valid_d = s1_valid_q;
                if (kill_i) begin
                    s1_valid_d = 1'b0;
                end else if (in_fire) begin
                    s1_valid_d = 1'b1;
                end else if (s1_adv) begin
                    s1_valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    mask_q     <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    if (in_fire) begin
                        mask_q <= mask_c;
                    end
                end
            end
        end else begin : g_bypass
            assign in_ready_o = !rst && !kill_i && s2_can_load;
            assign s2_load    = in_fire;
            assign cnt_src    = mask_c;
        end
    endgenerate

    // 32-bit population count; 6 bits hold the maximum of 32
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            cnt_d = cnt_d + CNT_W'(cnt_src[i]);
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (kill_i) begin
            s2_valid_d = 1'b0;
        end else if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready_i) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign result_o    = {(DATA_W-CNT_W)'(0), cnt_q};

endmodule

// File: tb/tb_cv32e40x_alu_b_count_unit.sv
// Scoreboard bench for the count unit; drives PREP_REG=1 and PREP_REG=0 instances
// from one stimulus stream, each with its own expected-result queue.
module tb_cv32e40x_alu_b_count_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  operator = 2'b00;
    logic [31:0] operand = '0;
    logic        out_ready = 1'b1;
    logic [5:0]  exp_in = '0;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] result1, result0;

    typedef struct { logic [5:0] exp; int cyc; } sb_t;
    sb_t  q [2][$];
    bit   prev_hold [2];
    logic [31:0] prev_res [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_bp  = -1;
    int stalls   = 0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    cv32e40x_alu_b_count_unit #(.PREP_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .kill_i(kill), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .operator_i(operator), .operand_i(operand), .out_valid_o(out_valid1),
        .out_ready_i(out_ready), .result_o(result1)
    );

    cv32e40x_alu_b_count_unit #(.PREP_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .kill_i(kill), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .operator_i(operator), .operand_i(operand), .out_valid_o(out_valid0),
        .out_ready_i(out_ready), .result_o(result0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d (0x%08h), expected %0d (0x%08h)",
                     name, cyc, act, act, exp, exp);
        end
    endtask

    // Independent reference: scan bits directly rather than building a mask
    function automatic logic [5:0] ref_count(input logic [1:0] op, input logic [31:0] x);
        int n = 0;
        bit stop = 1'b0;
        case (op)
            2'b01: for (int i = 31; i >= 0; i--) begin
                if (!stop) begin
                    if (x[i]) stop = 1'b1; else n++;
                end
            end
            2'b10: for (int i = 0; i < 32; i++) begin
                if (!stop) begin
                    if (x[i]) stop = 1'b1; else n++;
                end
            end
            default: for (int i = 0; i < 32; i++) n += int'(x[i]);
        endcase
        return 6'(n);
    endfunction

    task automatic mon(input int d, input logic rdy, input logic ov, input logic [31:0] res,
                       input int lat);
        sb_t e;
        if (prev_hold[d]) begin
            chk($sformatf("hold_valid_dut%0d", d), 32'(ov), 32'd1);
            chk($sformatf("hold_result_dut%0d", d), res, prev_res[d]);
        end
        if (rst || kill) begin
            q[d].delete();
            prev_hold[d] = 1'b0;
            prev_res[d]  = res;
        end else begin
            if (ov && out_ready) begin
                if (q[d].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output_dut%0d at cycle %0d: got %0d, expected none",
                             d, cyc, res);
                end else begin
                    e = q[d].pop_front();
                    chk($sformatf("result_dut%0d", d), res, {26'b0, e.exp});
                    if (last_bp < e.cyc)
                        chk($sformatf("latency_dut%0d", d), 32'(cyc - e.cyc), 32'(lat));
                end
            end
            if (in_valid && rdy) begin
                e.exp = exp_in;
                e.cyc = cyc;
                q[d].push_back(e);
            end
            prev_hold[d] = ov && !out_ready;
            prev_res[d]  = res;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!out_ready) last_bp = cyc;
        mon(0, in_ready0, out_valid0, result0, 1);
        mon(1, in_ready1, out_valid1, result1, 2);
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [5:0] e);
        bit acc;
        int t = 0;
        operator = op;
        operand  = x;
        exp_in   = e;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready1;
            @(posedge clk);
            #1;
            if (acc) break;
            stalls++;
            if (++t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout at cycle %0d: got no accept, expected one", cyc);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_kill(input logic [31:0] x);
        kill     = 1'b1;
        in_valid = 1'b1;
        operator = 2'b00;
        operand  = x;
        exp_in   = ref_count(2'b00, x);
        @(negedge clk);
        chk("kill_in_ready_dut1", 32'(in_ready1), 32'd0);
        chk("kill_in_ready_dut0", 32'(in_ready0), 32'd0);
        @(posedge clk);
        #1;
        kill     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("kill_out_valid_dut1", 32'(out_valid1), 32'd0);
        chk("kill_out_valid_dut0", 32'(out_valid0), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid_dut1", 32'(out_valid1), 32'd0);
        chk("rst_result_dut1", result1, 32'd0);
        chk("rst_in_ready_dut1", 32'(in_ready1), 32'd1);
        chk("rst_out_valid_dut0", 32'(out_valid0), 32'd0);
        chk("rst_result_dut0", result0, 32'd0);
        chk("rst_in_ready_dut0", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'h1 << $urandom_range(0, 31);
            2:       return $urandom() & $urandom() & $urandom();
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] x;
        int          r;

        do_reset(2);

        // Single operations and zero-operand boundaries
        issue(2'b00, 32'hFFFF_FFFF, 6'd32);
        issue(2'b01, 32'h0000_0001, 6'd31);
        issue(2'b10, 32'h8000_0000, 6'd31);
        issue(2'b01, 32'h8000_0000, 6'd0);
        issue(2'b00, 32'h0000_0000, 6'd0);
        issue(2'b01, 32'h0000_0000, 6'd32);
        issue(2'b10, 32'h0000_0000, 6'd32);
        issue(2'b11, 32'h0000_F00F, 6'd8);
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back CTZ stream at full throughput
        stalls = 0;
        for (int i = 0; i < 32; i++) begin
            x = 32'h1 << i;
            issue(2'b10, x, 6'(i));
        end
        chk("stream_no_stall", 32'(stalls), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two held, third stalls, then ordered drain
        out_ready = 1'b0;
        issue(2'b00, 32'h0000_000F, 6'd4);
        issue(2'b00, 32'h0000_00FF, 6'd8);
        operator = 2'b01;
        operand  = 32'h0000_FFFF;
        exp_in   = 6'd16;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_dut1", 32'(in_ready1), 32'd0);
            chk("bp_result_first", result1, 32'd4);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(2'b01, 32'h0000_FFFF, 6'd16);
        repeat (4) @(posedge clk);
        #1;

        // Kill with two in flight and a new operand in the kill cycle
        out_ready = 1'b0;
        issue(2'b00, 32'h0000_0003, 6'd2);
        issue(2'b00, 32'h0000_0007, 6'd3);
        do_kill(32'h0000_00FF);
        out_ready = 1'b1;
        issue(2'b10, 32'h0000_0100, 6'd8);
        repeat (4) @(posedge clk);
        #1;

        // Random regression with random ready, kills and mid-stream resets
        rand_rdy = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset(1);
            end else if (r < 10) begin
                do_kill($urandom());
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                op = 2'($urandom_range(0, 3));
                x  = rand_opnd();
                issue(op, x, ref_count(op, x));
            end
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;

        for (int t = 0; t < 20 && (q[0].size() != 0 || q[1].size() != 0); t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_dut1", 32'(q[1].size()), 32'd0);
        chk("drain_dut0", 32'(q[0].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
